// File: rtl/thee_sync_qual_pkg.sv
// Shared types and helpers for the synchronized-bus qualifier.
package thee_sync_qual_pkg;

    typedef enum logic {
        QS_IDLE = 1'b0,
        QS_PEND = 1'b1
    } qual_state_e;

    // Guarded so an illegal STABLE_CYCLES still yields a legal width before the
    // elaboration check in the top reports it.
    function automatic int cnt_width(input int stable);
        return (stable < 1) ? 1 : $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/thee_stable_cnt.sv
// Previous-sample register plus saturating run-length counter for the bus.
module thee_stable_cnt
    import thee_sync_qual_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               STABLE_CYCLES = 3,
    parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d_sync,
    output logic [WIDTH-1:0] d_prev,
    output logic             stable_hit
);

    localparam int            CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_prev <= RST_VAL;
            cnt    <= '0;
        end else begin
            d_prev <= d_sync;
            if (d_sync != d_prev) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Fires on the single edge that completes STABLE_CYCLES equal compares;
    // saturation keeps it from firing again while the value is held.
    assign stable_hit = (d_sync == d_prev) && (cnt == CNT_LAST);

endmodule

// File: rtl/thee_sync_bus_qualifier.sv
// Qualifies a synchronized multi-bit bus and hands stable values downstream on valid/ready.
module thee_sync_bus_qualifier
    import thee_sync_qual_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               STABLE_CYCLES = 3,
    parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d_sync,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             q_change,
    output logic             q_overrun
);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("thee_sync_bus_qualifier: STABLE_CYCLES must be >= 1");
    end

    qual_state_e      state, state_nxt;
    logic [WIDTH-1:0] d_prev;
    logic             stable_hit;
    logic             accept;

    thee_stable_cnt #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(STABLE_CYCLES),
        .RST_VAL      (RST_VAL)
    ) u_stable_cnt (
        .clk       (clk),
        .rstn      (rstn),
        .d_sync    (d_sync),
        .d_prev    (d_prev),
        .stable_hit(stable_hit)
    );

    // stable_hit implies d_sync == d_prev, so comparing the registered copy is equivalent.
    assign accept = stable_hit && (d_prev != q_data);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= QS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            QS_IDLE: if (accept)              state_nxt = QS_PEND;
            QS_PEND: if (q_ready && !accept)  state_nxt = QS_IDLE;
            default:                          state_nxt = QS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_data    <= RST_VAL;
            q_change  <= 1'b0;
            q_overrun <= 1'b0;
        end else begin
            q_change  <= accept;
            q_overrun <= accept && (state == QS_PEND) && !q_ready;
            if (accept) begin
                q_data <= d_sync;
            end
        end
    end

    assign q_valid = (state == QS_PEND);

endmodule

// File: tb/tb_thee_sync_bus_qualifier.sv
// Directed self-checking bench for thee_sync_bus_qualifier (WIDTH=4, STABLE_CYCLES=3).
module tb_thee_sync_bus_qualifier;

    localparam int W  = 4;
    localparam int SC = 3;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [W-1:0] d_sync = 4'b1010;
    logic [W-1:0] q_data;
    logic         q_valid;
    logic         q_ready = 1'b0;
    logic         q_change;
    logic         q_overrun;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    thee_sync_bus_qualifier #(
        .WIDTH        (W),
        .STABLE_CYCLES(SC),
        .RST_VAL      ('0)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .d_sync   (d_sync),
        .q_data   (q_data),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .q_change (q_change),
        .q_overrun(q_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_rstn(input int unsigned cycles);
        rstn = 1'b0;
        repeat (cycles) tick();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    logic [W-1:0] vals [4] = '{4'h9, 4'h6, 4'hF, 4'h3};
    logic [W-1:0] seen [8];
    int unsigned  n_seen;
    logic [W-1:0] prev, mask;

    initial begin
        // 1: reset holds outputs low; 1010 qualifies on the 4th edge after release
        #2;
        check("rst_data",    q_data,    0);
        check("rst_valid",   q_valid,   0);
        check("rst_change",  q_change,  0);
        check("rst_overrun", q_overrun, 0);
        toggle_rstn(2);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t1_early_change", q_change, 0);
            check("t1_early_valid",  q_valid,  0);
        end
        tick();
        check("t1_change", q_change, 1);
        check("t1_valid",  q_valid,  1);
        check("t1_data",   q_data,   4'b1010);
        tick();
        check("t1_change_pulse", q_change, 0);
        check("t1_hold_valid",   q_valid,  1);
        q_ready = 1'b1;
        tick();
        check("t1_consumed", q_valid, 0);
        q_ready = 1'b0;

        // 2: short glitch back to the reported value produces no event
        d_sync = 4'b0110;
        tick(); tick();
        d_sync = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t2_change", q_change, 0);
            check("t2_valid",  q_valid,  0);
        end
        check("t2_data", q_data, 4'b1010);

        // 3: two accepts without consumption; second overwrites the first
        d_sync = 4'b0011;
        for (int i = 1; i <= 12; i++) begin
            if (i == 7) d_sync = 4'b1100;
            tick();
            check("t3_change",  q_change,  (i == 4 || i == 10) ? 1 : 0);
            check("t3_overrun", q_overrun, (i == 10) ? 1 : 0);
        end
        check("t3_data",  q_data,  4'b1100);
        check("t3_valid", q_valid, 1);

        // 4: consume on the same edge a new value is accepted
        d_sync = 4'b0011;
        repeat (4) tick();
        check("t4_pend_data",    q_data,    4'b0011);
        check("t4_pend_overrun", q_overrun, 1);
        d_sync = 4'b1100;
        repeat (3) tick();
        check("t4_wait_data",   q_data,   4'b0011);
        check("t4_wait_change", q_change, 0);
        q_ready = 1'b1;
        tick();
        check("t4_valid",   q_valid,   1);
        check("t4_data",    q_data,    4'b1100);
        check("t4_change",  q_change,  1);
        check("t4_overrun", q_overrun, 0);
        tick();
        check("t4_drain", q_valid, 0);
        q_ready = 1'b0;

        // 5: asynchronous reset clears everything before the next edge
        d_sync = 4'b0101;
        repeat (4) tick();
        check("t5_pre_valid",  q_valid,  1);
        check("t5_pre_change", q_change, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("t5_valid",   q_valid,   0);
        check("t5_data",    q_data,    0);
        check("t5_change",  q_change,  0);
        check("t5_overrun", q_overrun, 0);
        d_sync = '0;
        toggle_rstn(2);

        // 6: skewed transitions with mixed-bit transient codes; only final values reported
        q_ready = 1'b1;
        n_seen  = 0;
        prev    = '0;
        foreach (vals[v]) begin
            for (int t = 0; t < 2; t++) begin
                mask   = W'($urandom_range(1, (1 << W) - 2));
                d_sync = (prev & mask) | (vals[v] & ~mask);
                tick();
                if (q_change && n_seen < 8) begin seen[n_seen] = q_data; n_seen++; end
            end
            d_sync = vals[v];
            repeat (STAGES + SC + 2) begin
                tick();
                if (q_change && n_seen < 8) begin seen[n_seen] = q_data; n_seen++; end
            end
            prev = vals[v];
        end
        check("t6_count", n_seen, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < int'(n_seen)) check("t6_order", seen[i], vals[i]);
            else                  check("t6_missing", 32'hFFFF_FFFF, vals[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
